// File: rtl/cam_init_seq.sv
// Camera register-init sequencer: walks the init ROM and issues one SCCB write per WRITE entry.
// Optional NACK retry is enabled by defining CAM_INIT_RETRY_EN.
module cam_init_seq #(
`ifdef CAM_INIT_RETRY_EN
  parameter int MAX_RETRY    = 3,
`endif
  parameter int ROM_DEPTH    = 96,
  parameter int TICKS_PER_MS = 50000,
  parameter int WRITE_GAP    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [7:0] romaddr,
  input  logic [1:0] t_cmd,
  input  logic [7:0] t_addr,
  input  logic [7:0] t_data,
  output logic       sccb_req,
  output logic [7:0] sccb_addr,
  output logic [7:0] sccb_data,
  input  logic       sccb_done,
  input  logic       sccb_nack,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] err_index
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_GAP, S_DELAY, S_NEXT, S_FIN, S_ERR
  } state_t;

  localparam logic [8:0] DEPTH9 = 9'(ROM_DEPTH);

  state_t      state_reg, state_next;
  logic [7:0]  romaddr_reg, romaddr_next;
  logic        req_reg, req_next;
  logic [7:0]  addr_reg, addr_next;
  logic [7:0]  data_reg, data_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        error_reg, error_next;
  logic [7:0]  err_index_reg, err_index_next;
  logic [31:0] cnt_reg, cnt_next;
  logic [31:0] tgt_reg, tgt_next;
  logic [8:0]  nxt_idx;
`ifdef CAM_INIT_RETRY_EN
  logic [7:0]  retry_cnt_reg, retry_cnt_next;
  logic        retry_pend_reg, retry_pend_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      romaddr_reg    <= 8'd0;
      req_reg        <= 1'b0;
      addr_reg       <= 8'd0;
      data_reg       <= 8'd0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
      err_index_reg  <= 8'd0;
      cnt_reg        <= 32'd0;
      tgt_reg        <= 32'd0;
`ifdef CAM_INIT_RETRY_EN
      retry_cnt_reg  <= 8'd0;
      retry_pend_reg <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      romaddr_reg    <= romaddr_next;
      req_reg        <= req_next;
      addr_reg       <= addr_next;
      data_reg       <= data_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      error_reg      <= error_next;
      err_index_reg  <= err_index_next;
      cnt_reg        <= cnt_next;
      tgt_reg        <= tgt_next;
`ifdef CAM_INIT_RETRY_EN
      retry_cnt_reg  <= retry_cnt_next;
      retry_pend_reg <= retry_pend_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    romaddr_next   = romaddr_reg;
    req_next       = req_reg;
    addr_next      = addr_reg;
    data_next      = data_reg;
    busy_next      = busy_reg;
    done_next      = done_reg;
    error_next     = error_reg;
    err_index_next = err_index_reg;
    cnt_next       = cnt_reg;
    tgt_next       = tgt_reg;
`ifdef CAM_INIT_RETRY_EN
    retry_cnt_next  = retry_cnt_reg;
    retry_pend_next = retry_pend_reg;
`endif
    nxt_idx = {1'b0, romaddr_reg} + 9'd1;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          romaddr_next = 8'd0;
          done_next    = 1'b0;
          error_next   = 1'b0;
          busy_next    = 1'b1;
          state_next   = S_FETCH;
        end
      end
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        cnt_next = 32'd0;
`ifdef CAM_INIT_RETRY_EN
        retry_cnt_next  = 8'd0;
        retry_pend_next = 1'b0;
`endif
        case (t_cmd)
          2'd0: state_next = S_FIN;
          2'd1: begin
            addr_next  = t_addr;
            data_next  = t_data;
            state_next = S_ISSUE;
          end
          2'd2: begin
            tgt_next   = 32'(t_data) * 32'(TICKS_PER_MS);
            state_next = (t_data == 8'd0) ? S_NEXT : S_DELAY;
          end
          default: state_next = S_NEXT;
        endcase
      end
      S_ISSUE: begin
        req_next   = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (sccb_done) begin
          req_next = 1'b0;
          cnt_next = 32'd0;
          if (!sccb_nack) state_next = S_GAP;
`ifdef CAM_INIT_RETRY_EN
          else if (retry_cnt_reg < 8'(MAX_RETRY)) begin
            retry_cnt_next  = retry_cnt_reg + 8'd1;
            retry_pend_next = 1'b1;
            state_next      = S_GAP;
          end
`endif
          else state_next = S_ERR;
        end
      end
      S_GAP: begin
        // A retried entry goes back to ISSUE with the already-registered addr/data
        if (cnt_reg == 32'(WRITE_GAP - 1)) begin
`ifdef CAM_INIT_RETRY_EN
          state_next      = retry_pend_reg ? S_ISSUE : S_NEXT;
          retry_pend_next = 1'b0;
`else
          state_next = S_NEXT;
`endif
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end
      S_DELAY: begin
        if (cnt_reg == tgt_reg - 32'd1) state_next = S_NEXT;
        else cnt_next = cnt_reg + 32'd1;
      end
      S_NEXT: begin
        // Saturate at 255 so the index never wraps back into the table
        romaddr_next = nxt_idx[8] ? 8'hFF : nxt_idx[7:0];
        state_next   = (nxt_idx >= DEPTH9 || nxt_idx[8]) ? S_FIN : S_FETCH;
      end
      S_FIN: begin
        busy_next  = 1'b0;
        done_next  = 1'b1;
        state_next = S_IDLE;
      end
      S_ERR: begin
        busy_next      = 1'b0;
        error_next     = 1'b1;
        err_index_next = romaddr_reg;
        state_next     = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign romaddr   = romaddr_reg;
  assign sccb_req  = req_reg;
  assign sccb_addr = addr_reg;
  assign sccb_data = data_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign error     = error_reg;
  assign err_index = err_index_reg;

endmodule

// File: tb/tb_cam_init_seq.sv
// Self-checking bench for cam_init_seq: ROM/SCCB-slave models, transaction-level expected writes.
module tb_cam_init_seq;
  localparam int ROM_DEPTH = 96;
  localparam int TPM       = 10;
  localparam int GAP       = 16;
  localparam int ACK_DLY   = 10;
`ifdef CAM_INIT_RETRY_EN
  localparam int MAXR = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start;
  logic [7:0] romaddr;
  logic [1:0] t_cmd;
  logic [7:0] t_addr, t_data;
  logic       sccb_req, sccb_done, sccb_nack;
  logic [7:0] sccb_addr, sccb_data;
  logic       busy, done, error;
  logic [7:0] err_index;

  logic [17:0] rom [0:255];
  int nack_plan [0:255];
  int att [0:255];
  int chg_cyc [0:255];

  logic start_drv = 1'b0, noise_start = 1'b0, noise_done = 1'b0;
  logic ack_done = 1'b0, ack_nack = 1'b0;
  bit   noise_en = 0;
  int   nz = 0, ack_cnt = 0;

  assign t_cmd     = rom[romaddr][17:16];
  assign t_addr    = rom[romaddr][15:8];
  assign t_data    = rom[romaddr][7:0];
  assign start     = start_drv | noise_start;
  assign sccb_done = ack_done | noise_done;
  assign sccb_nack = ack_nack | noise_done;

  cam_init_seq #(.ROM_DEPTH(ROM_DEPTH), .TICKS_PER_MS(TPM), .WRITE_GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .romaddr(romaddr),
    .t_cmd(t_cmd), .t_addr(t_addr), .t_data(t_data),
    .sccb_req(sccb_req), .sccb_addr(sccb_addr), .sccb_data(sccb_data),
    .sccb_done(sccb_done), .sccb_nack(sccb_nack),
    .busy(busy), .done(done), .error(error), .err_index(err_index)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected behaviour derived from the ROM contents and the NACK plan
  logic [15:0] exp_q [$];
  bit   exp_done, exp_error;
  int   exp_err_idx, exp_romaddr;

  function automatic void build_model();
    int idx = 0;
    int attempts;
    bit stop = 0, fail;
    exp_q.delete();
    exp_done = 0; exp_error = 0; exp_err_idx = 0; exp_romaddr = 0;
    while (!stop) begin
      if (idx >= ROM_DEPTH) begin
        exp_done = 1; exp_romaddr = idx; stop = 1;
      end else begin
        case (rom[idx][17:16])
          2'd0: begin exp_done = 1; exp_romaddr = idx; stop = 1; end
          2'd1: begin
`ifdef CAM_INIT_RETRY_EN
            fail     = nack_plan[idx] > MAXR;
            attempts = fail ? MAXR + 1 : nack_plan[idx] + 1;
`else
            fail     = nack_plan[idx] > 0;
            attempts = 1;
`endif
            for (int a = 0; a < attempts; a++) exp_q.push_back(rom[idx][15:0]);
            if (fail) begin
              exp_error = 1; exp_err_idx = idx; exp_romaddr = idx; stop = 1;
            end else idx++;
          end
          default: idx++;
        endcase
      end
    end
  endfunction

  // Compare process: every req rise must be the next expected write, held stable while req=1
  int wr_cnt = 0;
  int rise_q [$];
  int fall_q [$];
  logic [15:0] cap_q [$];
  logic prev_req = 1'b0;
  logic [7:0] prev_ra = 8'd0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req = 1'b0;
    end else begin
      if (romaddr !== prev_ra) chg_cyc[romaddr] = cyc;
      prev_ra = romaddr;
      if (sccb_req && !prev_req) begin
        rise_q.push_back(cyc);
        cap_q.push_back({sccb_addr, sccb_data});
        if (wr_cnt < exp_q.size()) check("write_value", {sccb_addr, sccb_data}, exp_q[wr_cnt]);
        else begin
          n_chk++; n_fail++;
          $display("FAIL extra_write: got write %0d expected only %0d", wr_cnt + 1, exp_q.size());
        end
        wr_cnt++;
      end else if (sccb_req && wr_cnt >= 1 && wr_cnt <= exp_q.size()) begin
        check("req_hold", {sccb_addr, sccb_data}, exp_q[wr_cnt - 1]);
      end
      if (sccb_req) check("busy_during_req", busy, 1);
      if (!sccb_req && prev_req) fall_q.push_back(cyc);
      prev_req = sccb_req;
    end
  end

  // SCCB slave: ack after ACK_DLY cycles; NACK the first nack_plan[i] attempts of entry i
  always @(negedge clk) begin
    ack_done = 1'b0; ack_nack = 1'b0;
    noise_done = 1'b0; noise_start = 1'b0;
    if (!rst_n || !sccb_req) ack_cnt = 0;
    else if (ack_cnt == ACK_DLY - 1) begin
      ack_done = 1'b1;
      att[romaddr]++;
      ack_nack = (att[romaddr] <= nack_plan[romaddr]);
      ack_cnt = 0;
    end else ack_cnt++;
    if (noise_en && rst_n && busy) begin
      nz++;
      if (!sccb_req && (nz % 5 == 0)) noise_done = 1'b1;
      if (nz % 7 == 3) noise_start = 1'b1;
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) begin rom[i] = 18'd0; nack_plan[i] = 0; end
  endtask

  int start_cyc;
  task automatic start_seq();
    for (int i = 0; i < 256; i++) begin att[i] = 0; chg_cyc[i] = 0; end
    build_model();
    wr_cnt = 0; rise_q.delete(); fall_q.delete(); cap_q.delete();
    @(negedge clk);
    start_drv = 1'b1; start_cyc = cyc;
    @(negedge clk);
    start_drv = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic finish_seq(input string tn, input int budget);
    int k = 0;
    while (busy === 1'b1 && k < budget) begin @(negedge clk); k++; end
    if (k >= budget) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: busy still %0b after %0d cycles, required 0", tn, busy, budget);
    end
    repeat (30) @(negedge clk);
    check({tn, "_writes"}, wr_cnt, exp_q.size());
    check({tn, "_busy"}, busy, 0);
    check({tn, "_done"}, done, exp_done);
    check({tn, "_error"}, error, exp_error);
    check({tn, "_romaddr"}, romaddr, exp_romaddr);
    if (exp_error) check({tn, "_err_index"}, err_index, exp_err_idx);
  endtask

  task automatic check_reset_outputs(input string tn);
    check({tn, "_romaddr"}, romaddr, 0);
    check({tn, "_req"}, sccb_req, 0);
    check({tn, "_addr"}, sccb_addr, 0);
    check({tn, "_data"}, sccb_data, 0);
    check({tn, "_busy"}, busy, 0);
    check({tn, "_done"}, done, 0);
    check({tn, "_error"}, error, 0);
    check({tn, "_err_index"}, err_index, 0);
  endtask

  initial begin
    clear_rom();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: two writes then END
    clear_rom();
    rom[0] = {2'd1, 8'h12, 8'h80}; rom[1] = {2'd1, 8'h11, 8'h01};
    start_seq();
    finish_seq("t1", 2000);
    check("t1_model_writes", exp_q.size(), 2);
    check("t1_write_count", wr_cnt, 2);
    if (cap_q.size() >= 2) begin
      check("t1_first_write", cap_q[0], 16'h1280);
      check("t1_second_write", cap_q[1], 16'h1101);
    end else check("t1_captured", cap_q.size(), 2);
    check("t1_romaddr_lit", romaddr, 2);
    check("t1_done_lit", done, 1);
    if (rise_q.size() >= 2 && fall_q.size() >= 1) begin
      check("t1_start_latency", rise_q[0] - start_cyc, 4);
      check("t1_write_spacing", rise_q[1] - fall_q[0], GAP + 4);
    end else check("t1_rises", rise_q.size(), 2);
    $display("t1 writes=%0d done=%0b romaddr=%0d", wr_cnt, done, romaddr);

    // T2: 5 ms DELAY, NOP and zero-length DELAY
    clear_rom();
    rom[0] = {2'd1, 8'h12, 8'h80}; rom[1] = {2'd2, 8'h00, 8'h05};
    rom[2] = {2'd1, 8'h11, 8'h01}; rom[3] = {2'd3, 8'h00, 8'h00};
    rom[4] = {2'd2, 8'h00, 8'h00}; rom[5] = {2'd1, 8'h22, 8'h33};
    start_seq();
    finish_seq("t2", 3000);
    if (rise_q.size() >= 2) check("t2_delay_to_req", rise_q[1] - chg_cyc[1], 5 * TPM + 6);
    else check("t2_rises", rise_q.size(), 3);
    check("t2_nop_step", chg_cyc[4] - chg_cyc[3], 3);
    check("t2_zero_delay_step", chg_cyc[5] - chg_cyc[4], 3);
    check("t2_romaddr_lit", romaddr, 6);
    $display("t2 writes=%0d delay_to_req=%0d", wr_cnt, rise_q.size() >= 2 ? rise_q[1] - chg_cyc[1] : -1);

    // T3: NACK on entry 3
    clear_rom();
    for (int i = 0; i < 6; i++) rom[i] = {2'd1, 8'(i), 8'(8'hA0 + i)};
`ifdef CAM_INIT_RETRY_EN
    nack_plan[3] = 2;
`else
    nack_plan[3] = 1;
`endif
    start_seq();
    finish_seq("t3", 4000);
`ifdef CAM_INIT_RETRY_EN
    check("t3_writes_lit", wr_cnt, 8);
    check("t3_done_lit", done, 1);
    check("t3_entry3_attempts", att[3], 3);
`else
    check("t3_writes_lit", wr_cnt, 4);
    check("t3_error_lit", error, 1);
    check("t3_err_index_lit", err_index, 3);
    check("t3_done_lit", done, 0);
`endif
    $display("t3 writes=%0d done=%0b error=%0b err_index=%0d", wr_cnt, done, error, err_index);

    // T4: no END entry, scan stops at ROM_DEPTH
    clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = {2'd1, 8'(i), 8'(~i)};
    start_seq();
    finish_seq("t4", 10000);
    check("t4_writes_lit", wr_cnt, 96);
    check("t4_romaddr_lit", romaddr, 96);
    $display("t4 writes=%0d done=%0b romaddr=%0d", wr_cnt, done, romaddr);

    // T5: async reset during WAIT on entry 5, then replay from entry 0
    clear_rom();
    for (int i = 0; i < 12; i++) rom[i] = {2'd1, 8'(8'h40 + i), 8'(i * 3)};
    start_seq();
    begin
      int k = 0;
      while (!(romaddr == 8'd5 && sccb_req) && k < 2000) begin @(negedge clk); k++; end
      if (k >= 2000) begin
        n_chk++; n_fail++;
        $display("FAIL t5_reach_wait: entry 5 write not seen within %0d cycles", k);
      end
    end
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("t5_async_reset");
    @(negedge clk);
    check_reset_outputs("t5_held_reset");
    @(negedge clk);
    rst_n = 1'b1;
    start_seq();
    finish_seq("t5", 4000);
    if (cap_q.size() >= 1) check("t5_replay_first", cap_q[0], 16'h4000);
    check("t5_writes_lit", wr_cnt, 12);
    $display("t5 writes_after_reset=%0d done=%0b", wr_cnt, done);

    // T6: start pulses while busy and spurious sccb_done outside WAIT
    clear_rom();
    for (int i = 0; i < 4; i++) rom[i] = {2'd1, 8'(8'h70 + i), 8'(8'h0F + i)};
    rom[4] = {2'd2, 8'h00, 8'h01};
    noise_en = 1;
    start_seq();
    finish_seq("t6", 3000);
    noise_en = 0;
    check("t6_writes_lit", wr_cnt, 4);
    check("t6_romaddr_lit", romaddr, 5);
    $display("t6 writes=%0d done=%0b error=%0b", wr_cnt, done, error);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end
endmodule
